// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer for two-player Pong.
// Detects per-frame paddle misses, keeps both scores, sequences
// SERVE / PLAY / POINT / GAMEOVER and drives the ball/paddle resets,
// the scoreboard strobes and the game-over overlay enable.
// Optional build macro: PONG_START_BTN_EN adds an IDLE state that waits
// for a rising edge of i_start (entered after reset and after game over).
module pong_match_ctrl #(
  parameter int VRES            = 720,
  parameter int PADDLE_H        = 20,
  parameter int WIN_SCORE       = 7,
  parameter int SERVE_FRAMES    = 60,
  parameter int POINT_FRAMES    = 64,
  parameter int GAMEOVER_FRAMES = 128
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               i_fsync,
  input  logic signed [11:0] i_vpos,
  input  logic               i_active_obj,
  input  logic               i_active_paddle_p1,
  input  logic               i_active_paddle_p2,
  input  logic               i_start,
  output logic               o_obj_rst,
  output logic               o_paddle_rst,
  output logic [1:0]         o_score_inc,
  output logic [3:0]         o_score_p1,
  output logic [3:0]         o_score_p2,
  output logic [1:0]         o_winner,
  output logic               o_show_gameover,
  output logic [2:0]         o_state
);

  localparam logic signed [11:0] BOT_ROW = 12'(VRES - PADDLE_H);
  localparam logic signed [11:0] TOP_ROW = 12'(PADDLE_H - 1);

  // A pause length of 0 behaves like a single frame.
  localparam logic [7:0] SERVE_LAST    = (SERVE_FRAMES    <= 1) ? 8'd0 : 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST    = (POINT_FRAMES    <= 1) ? 8'd0 : 8'(POINT_FRAMES - 1);
  localparam logic [7:0] GAMEOVER_LAST = (GAMEOVER_FRAMES <= 1) ? 8'd0 : 8'(GAMEOVER_FRAMES - 1);
  localparam logic [3:0] WIN           = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    ST_SERVE    = 3'd0,
    ST_PLAY     = 3'd1,
    ST_POINT    = 3'd2,
    ST_GAMEOVER = 3'd3,
    ST_IDLE     = 3'd4
  } state_t;

`ifdef PONG_START_BTN_EN
  localparam state_t RESET_STATE    = ST_IDLE;
  localparam state_t AFTER_GAMEOVER = ST_IDLE;
`else
  localparam state_t RESET_STATE    = ST_SERVE;
  localparam state_t AFTER_GAMEOVER = ST_SERVE;
`endif

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_frame_cnt;
  logic        r_touch_bot;
  logic        r_hit_bot;
  logic        r_touch_top;
  logic        r_hit_top;
  logic [3:0]  r_score_p1;
  logic [3:0]  r_score_p2;
  logic [1:0]  r_winner;
  logic [1:0]  r_score_inc;
  logic        r_obj_rst;
  logic        r_paddle_rst;
  logic        r_show_gameover;

  logic        w_cnt_clear;
  logic        w_cnt_inc;
  logic [1:0]  w_score_evt;
  logic        w_clear_match;
  logic        w_miss_bot;
  logic        w_miss_top;
  logic [3:0]  w_p1_next;
  logic [3:0]  w_p2_next;
  logic        w_at_bot;
  logic        w_at_top;
  logic        w_start_rise;

  // Signed compare: negative blanking lines can never equal a row.
  assign w_at_bot   = (i_vpos == BOT_ROW);
  assign w_at_top   = (i_vpos == TOP_ROW);
  assign w_miss_bot = r_touch_bot & ~r_hit_bot;
  assign w_miss_top = r_touch_top & ~r_hit_top;
  assign w_p1_next  = (r_score_p1 == 4'd15) ? 4'd15 : r_score_p1 + 4'd1;
  assign w_p2_next  = (r_score_p2 == 4'd15) ? 4'd15 : r_score_p2 + 4'd1;

`ifdef PONG_START_BTN_EN
  logic r_start_d;

  // Previous start level; sampled through reset so a held button is no edge.
  always_ff @(posedge pixel_clk) begin
    r_start_d <= i_start;
  end

  assign w_start_rise = i_start & ~r_start_d;
`else
  logic w_unused_start;
  assign w_unused_start = i_start;
  assign w_start_rise   = 1'b0;
`endif

  // State register.
  always_ff @(posedge pixel_clk) begin
    if (rst) r_state <= RESET_STATE;
    else     r_state <= w_state_next;
  end

  // Next-state logic, frame-counter control and point awarding.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_clear   = 1'b0;
    w_cnt_inc     = 1'b0;
    w_score_evt   = 2'b00;
    w_clear_match = 1'b0;
    case (r_state)
      ST_SERVE: begin
        if (i_fsync) begin
          if (r_frame_cnt == SERVE_LAST) begin
            w_state_next = ST_PLAY;
            w_cnt_clear  = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (i_fsync) begin
          if (w_miss_bot) begin
            w_score_evt  = 2'b10;
            w_cnt_clear  = 1'b1;
            w_state_next = (w_p2_next == WIN) ? ST_GAMEOVER : ST_POINT;
          end else if (w_miss_top) begin
            w_score_evt  = 2'b01;
            w_cnt_clear  = 1'b1;
            w_state_next = (w_p1_next == WIN) ? ST_GAMEOVER : ST_POINT;
          end
        end
      end
      ST_POINT: begin
        if (i_fsync) begin
          if (r_frame_cnt == POINT_LAST) begin
            w_state_next = ST_SERVE;
            w_cnt_clear  = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      ST_GAMEOVER: begin
        if (i_fsync) begin
          if (r_frame_cnt == GAMEOVER_LAST) begin
            w_state_next  = AFTER_GAMEOVER;
            w_cnt_clear   = 1'b1;
            w_clear_match = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (w_start_rise) w_state_next = ST_SERVE;
      end
      default: w_state_next = RESET_STATE;
    endcase
  end

  // Frame counter: counts fsyncs in the pause states, clears on transitions.
  always_ff @(posedge pixel_clk) begin
    if (rst || w_cnt_clear) r_frame_cnt <= 8'd0;
    else if (w_cnt_inc)     r_frame_cnt <= r_frame_cnt + 8'd1;
  end

  // Per-frame touch/hit flags; the fsync clear wins over a same-cycle set.
  always_ff @(posedge pixel_clk) begin
    if (rst || i_fsync) begin
      r_touch_bot <= 1'b0;
      r_hit_bot   <= 1'b0;
      r_touch_top <= 1'b0;
      r_hit_top   <= 1'b0;
    end else begin
      if (w_at_bot && i_active_obj)                       r_touch_bot <= 1'b1;
      if (w_at_bot && i_active_obj && i_active_paddle_p1) r_hit_bot   <= 1'b1;
      if (w_at_top && i_active_obj)                       r_touch_top <= 1'b1;
      if (w_at_top && i_active_obj && i_active_paddle_p2) r_hit_top   <= 1'b1;
    end
  end

  // Scores, winner and the one-cycle scoreboard strobes.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_score_p1  <= 4'd0;
      r_score_p2  <= 4'd0;
      r_winner    <= 2'b00;
      r_score_inc <= 2'b00;
    end else begin
      r_score_inc <= w_score_evt;
      if (w_score_evt[0]) r_score_p1 <= w_p1_next;
      if (w_score_evt[1]) r_score_p2 <= w_p2_next;
      if ((w_score_evt != 2'b00) && (w_state_next == ST_GAMEOVER)) r_winner <= w_score_evt;
      if (w_clear_match) begin
        r_score_p1 <= 4'd0;
        r_score_p2 <= 4'd0;
        r_winner   <= 2'b00;
      end
    end
  end

  // Registered state-decoded outputs, so reset shows both reset lines high.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_obj_rst       <= 1'b1;
      r_paddle_rst    <= 1'b1;
      r_show_gameover <= 1'b0;
    end else begin
      r_obj_rst       <= (w_state_next != ST_PLAY);
      r_paddle_rst    <= (w_state_next == ST_GAMEOVER) || (w_state_next == ST_IDLE);
      r_show_gameover <= (w_state_next == ST_GAMEOVER);
    end
  end

  assign o_obj_rst       = r_obj_rst;
  assign o_paddle_rst    = r_paddle_rst;
  assign o_score_inc     = r_score_inc;
  assign o_score_p1      = r_score_p1;
  assign o_score_p2      = r_score_p2;
  assign o_winner        = r_winner;
  assign o_show_gameover = r_show_gameover;
  assign o_state         = r_state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed bench for pong_match_ctrl.
// A "frame" here is four clocks: fsync, line 19, line 700, blanking.
// Honours PONG_START_BTN_EN when the bench is built with it defined.
module tb_pong_match_ctrl;

  logic               pixel_clk = 1'b0;
  logic               rst;
  logic               fsync;
  logic signed [11:0] vpos;
  logic               activeObj;
  logic               paddleP1;
  logic               paddleP2;
  logic               start;
  logic               objRst;
  logic               paddleRst;
  logic [1:0]         scoreInc;
  logic [3:0]         scoreP1;
  logic [3:0]         scoreP2;
  logic [1:0]         winner;
  logic               showGameover;
  logic [2:0]         stateO;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] ST_SERVE    = 3'd0;
  localparam logic [2:0] ST_PLAY     = 3'd1;
  localparam logic [2:0] ST_POINT    = 3'd2;
  localparam logic [2:0] ST_GAMEOVER = 3'd3;
`ifdef PONG_START_BTN_EN
  localparam logic [2:0] ST_RST      = 3'd4;
  localparam logic       RESTART_PAD = 1'b1;
`else
  localparam logic [2:0] ST_RST      = 3'd0;
  localparam logic       RESTART_PAD = 1'b0;
`endif

  always #5 pixel_clk = ~pixel_clk;

  pong_match_ctrl dut (
    .pixel_clk          (pixel_clk),
    .rst                (rst),
    .i_fsync            (fsync),
    .i_vpos             (vpos),
    .i_active_obj       (activeObj),
    .i_active_paddle_p1 (paddleP1),
    .i_active_paddle_p2 (paddleP2),
    .i_start            (start),
    .o_obj_rst          (objRst),
    .o_paddle_rst       (paddleRst),
    .o_score_inc        (scoreInc),
    .o_score_p1         (scoreP1),
    .o_score_p2         (scoreP2),
    .o_winner           (winner),
    .o_show_gameover    (showGameover),
    .o_state            (stateO)
  );

  // Counts one comparison and reports it if the values differ.
  task checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One clock, leaving us 1 ns past the rising edge.
  task tick();
    @(posedge pixel_clk);
    #1;
  endtask

  // One-cycle frame-start pulse on a blanking line.
  task pulseFsync();
    fsync = 1'b1; vpos = -12'sd3; activeObj = 1'b0; paddleP1 = 1'b0; paddleP2 = 1'b0;
    tick();
    fsync = 1'b0;
  endtask

  // Frame body: ball/paddle activity on the top row, then the bottom row.
  task frameBody(input logic ballTop, input logic padTop, input logic ballBot, input logic padBot);
    vpos = 12'sd19;  activeObj = ballTop; paddleP2 = padTop; paddleP1 = 1'b0;
    tick();
    vpos = 12'sd700; activeObj = ballBot; paddleP1 = padBot; paddleP2 = 1'b0;
    tick();
    vpos = -12'sd1;  activeObj = 1'b0; paddleP1 = 1'b0; paddleP2 = 1'b0;
    tick();
  endtask

  // A whole frame: fsync followed by the body.
  task applyStimulus(input logic ballTop, input logic padTop, input logic ballBot, input logic padBot);
    pulseFsync();
    frameBody(ballTop, padTop, ballBot, padBot);
  endtask

  task emptyFrames(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Leaves IDLE with a start press when the button feature is built in.
  task startMatch();
`ifdef PONG_START_BTN_EN
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("startToServe", stateO, ST_SERVE);
    tick();
`endif
  endtask

  // From the start of SERVE: 60 fsyncs, then sit just past the entry to PLAY.
  task serveToPlay();
    emptyFrames(59);
    checkOutput("serveHold", stateO, ST_SERVE);
    pulseFsync();
    checkOutput("playState", stateO, ST_PLAY);
    checkOutput("playObjRst", objRst, 1'b0);
  endtask

  // From just after a point: 64 frames of POINT, then back into PLAY.
  task pointToPlay();
    frameBody(1'b0, 1'b0, 1'b0, 1'b0);
    emptyFrames(63);
    checkOutput("pointHold", stateO, ST_POINT);
    pulseFsync();
    checkOutput("pointToServe", stateO, ST_SERVE);
    frameBody(1'b0, 1'b0, 1'b0, 1'b0);
    serveToPlay();
  endtask

  initial begin
    rst = 1'b1; fsync = 1'b0; vpos = 12'sd0; activeObj = 1'b0; paddleP1 = 1'b0; paddleP2 = 1'b0;
`ifdef PONG_START_BTN_EN
    start = 1'b1;
`else
    start = 1'b0;
`endif
    tick();
    tick();
    checkOutput("rstState", stateO, ST_RST);
    checkOutput("rstObj", objRst, 1'b1);
    checkOutput("rstPaddle", paddleRst, 1'b1);
    checkOutput("rstScores", {scoreP2, scoreP1}, 8'h00);
    checkOutput("rstWinner", winner, 2'b00);
    checkOutput("rstInc", scoreInc, 2'b00);
    checkOutput("rstOverlay", showGameover, 1'b0);
    rst = 1'b0;
    tick();
`ifdef PONG_START_BTN_EN
    tick();
    tick();
    checkOutput("idleHeldStart", stateO, 3'd4);
    checkOutput("idlePaddle", paddleRst, 1'b1);
    start = 1'b0;
    tick();
    startMatch();
`endif
    checkOutput("servePaddle", paddleRst, 1'b0);
    checkOutput("serveObj", objRst, 1'b1);

    // Serve delay, then a bottom hit and a top hit score nothing.
    frameBody(1'b0, 1'b0, 1'b0, 1'b0);
    serveToPlay();
    checkOutput("playScores", {scoreP2, scoreP1}, 8'h00);
    frameBody(1'b0, 1'b0, 1'b1, 1'b1);
    pulseFsync();
    checkOutput("botHitInc", scoreInc, 2'b00);
    checkOutput("botHitState", stateO, ST_PLAY);
    frameBody(1'b1, 1'b1, 1'b0, 1'b0);
    pulseFsync();
    checkOutput("topHitInc", scoreInc, 2'b00);

    // Ball on the bottom row only during an fsync: the clear wins.
    frameBody(1'b0, 1'b0, 1'b0, 1'b0);
    fsync = 1'b1; vpos = 12'sd700; activeObj = 1'b1;
    tick();
    fsync = 1'b0;
    frameBody(1'b0, 1'b0, 1'b0, 1'b0);
    pulseFsync();
    checkOutput("fsyncPrioInc", scoreInc, 2'b00);
    checkOutput("fsyncPrioState", stateO, ST_PLAY);

    // Bottom miss: P2 scores, one-cycle strobe, POINT pause.
    frameBody(1'b0, 1'b0, 1'b1, 1'b0);
    pulseFsync();
    checkOutput("botMissInc", scoreInc, 2'b10);
    checkOutput("botMissP2", scoreP2, 4'd1);
    checkOutput("botMissState", stateO, ST_POINT);
    checkOutput("botMissObj", objRst, 1'b1);
    tick();
    checkOutput("incOneCycle", scoreInc, 2'b00);
    pointToPlay();

    // Both rows missed in one frame: only the bottom miss counts.
    frameBody(1'b1, 1'b0, 1'b1, 1'b0);
    pulseFsync();
    checkOutput("dualMissInc", scoreInc, 2'b10);
    checkOutput("dualMissScores", {scoreP2, scoreP1}, 8'h20);
    pointToPlay();

    // Top miss: P1 scores.
    frameBody(1'b1, 1'b0, 1'b0, 1'b0);
    pulseFsync();
    checkOutput("topMissInc", scoreInc, 2'b01);
    checkOutput("topMissScores", {scoreP2, scoreP1}, 8'h21);
    pointToPlay();

    // Reset in the middle of PLAY drops everything.
    rst = 1'b1;
    tick();
    checkOutput("midRstState", stateO, ST_RST);
    checkOutput("midRstScores", {scoreP2, scoreP1}, 8'h00);
    checkOutput("midRstObj", objRst, 1'b1);
    checkOutput("midRstPaddle", paddleRst, 1'b1);
    rst = 1'b0;
    tick();
    startMatch();
    frameBody(1'b0, 1'b0, 1'b0, 1'b0);
    serveToPlay();

    // P1 wins by seven top misses.
    for (int k = 1; k <= 6; k++) begin
      frameBody(1'b1, 1'b0, 1'b0, 1'b0);
      pulseFsync();
      checkOutput("winRunP1", scoreP1, 8'(k));
      pointToPlay();
    end
    frameBody(1'b1, 1'b0, 1'b0, 1'b0);
    pulseFsync();
    checkOutput("winP1", scoreP1, 4'd7);
    checkOutput("winWinner", winner, 2'b01);
    checkOutput("winOverlay", showGameover, 1'b1);
    checkOutput("winState", stateO, ST_GAMEOVER);
    checkOutput("winInc", scoreInc, 2'b01);
    checkOutput("winPaddle", paddleRst, 1'b1);
    frameBody(1'b0, 1'b0, 1'b0, 1'b0);
    emptyFrames(127);
    checkOutput("gameoverHold", stateO, ST_GAMEOVER);
    checkOutput("gameoverWinner", winner, 2'b01);
    pulseFsync();
    checkOutput("restartState", stateO, ST_RST);
    checkOutput("restartScores", {scoreP2, scoreP1}, 8'h00);
    checkOutput("restartWinner", winner, 2'b00);
    checkOutput("restartOverlay", showGameover, 1'b0);
    checkOutput("restartPaddle", paddleRst, RESTART_PAD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
